// File: rtl/pcs_pma_status_monitor_pkg.sv
// Shared definitions for the 10GBASE-R PCS/PMA status monitor.
// Holds the link qualification state encoding, the default status_vector
// bit positions, the configuration_vector clear bit index and a small
// helper used to size the shared qualification/holdoff counter.
package pcs_pma_status_monitor_pkg;

    typedef enum logic [1:0] {
        ST_DOWN = 2'd0,
        ST_QUAL = 2'd1,
        ST_UP   = 2'd2,
        ST_HOLD = 2'd3
    } link_state_t;

    localparam int STATUS_VECTOR_W        = 448;
    localparam int CORE_STATUS_W          = 8;
    localparam int DEFAULT_BLOCK_LOCK_BIT = 256;
    localparam int DEFAULT_HI_BER_BIT     = 257;
    localparam int CFG_CLEAR_PCS_STATUS2  = 518;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pcs_pma_status_monitor_sat_counter.sv
// Saturating event counter.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset, clears the count
//   inc  - count one event this cycle
//   clr  - zero the count; wins over a same-cycle inc (that event is lost)
//   q    - current count, sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    // Clear has priority; increments stop once the counter is full
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/pcs_pma_status_monitor.sv
// Status-side monitor for one 10GBASE-R PCS/PMA port on the 156.25 MHz core clock.
// Registers block lock and hi_ber from the core, debounces link-up through a
// DOWN/QUAL/UP/HOLD state machine, keeps sticky fault flags and saturating
// counters for link drops and hi_ber events.
// Ports:
//   clk156, rst          - core clock, synchronous active-high reset
//   status_vector[447:0] - core status vector (block lock / hi_ber bits)
//   core_status[7:0]     - core status, bit0 is also PCS block lock
//   clear_counters       - pulse: zero both event counters
//   clear_sticky         - pulse: clear sticky flags
//   link_up              - qualified link status
//   link_up_pulse        - one cycle on entering UP
//   link_down_pulse      - one cycle on leaving UP
//   sticky_lock_lost     - block lock has fallen since last clear
//   sticky_hi_ber        - hi_ber has risen since last clear
//   link_drop_cnt        - saturating count of UP->HOLD transitions
//   hi_ber_cnt           - saturating count of hi_ber rising edges
//   cfg_clear_status2    - clear_sticky delayed one cycle, for configuration_vector
module pcs_pma_status_monitor
    import pcs_pma_status_monitor_pkg::*;
#(
    parameter int QUAL_CYCLES    = 16384,
    parameter int HOLDOFF_CYCLES = 4096,
    parameter int CNT_W          = 16,
    parameter int BLOCK_LOCK_BIT = DEFAULT_BLOCK_LOCK_BIT,
    parameter int HI_BER_BIT     = DEFAULT_HI_BER_BIT
) (
    input  logic                       clk156,
    input  logic                       rst,
    input  logic [STATUS_VECTOR_W-1:0] status_vector,
    input  logic [CORE_STATUS_W-1:0]   core_status,
    input  logic                       clear_counters,
    input  logic                       clear_sticky,
    output logic                       link_up,
    output logic                       link_up_pulse,
    output logic                       link_down_pulse,
    output logic                       sticky_lock_lost,
    output logic                       sticky_hi_ber,
    output logic [CNT_W-1:0]           link_drop_cnt,
    output logic [CNT_W-1:0]           hi_ber_cnt,
    output logic                       cfg_clear_status2
);

    // One counter serves both QUAL and HOLD, sized for the longer of the two
    localparam int CTR_W = $clog2(max_int(QUAL_CYCLES, HOLDOFF_CYCLES));
    localparam logic [CTR_W-1:0] QUAL_LAST = CTR_W'(QUAL_CYCLES - 1);
    localparam logic [CTR_W-1:0] HOLD_LAST = CTR_W'(HOLDOFF_CYCLES - 1);

    logic              lock_r, lock_rr, hiber_r, hiber_rr;
    logic              good, lock_fall, hiber_rise;
    link_state_t       state, state_nxt;
    logic [CTR_W-1:0]  ctr, ctr_nxt;
    logic              up_pulse_nxt, down_pulse_nxt;
    logic              unused_inputs;

    // Only two status bits and core_status[0] matter here
    assign unused_inputs = ^{status_vector, core_status[CORE_STATUS_W-1:1]};

    // Input registers; the second stage exists only for edge detection
    always_ff @(posedge clk156) begin
        if (rst) begin
            lock_r   <= 1'b0;
            lock_rr  <= 1'b0;
            hiber_r  <= 1'b0;
            hiber_rr <= 1'b0;
        end else begin
            lock_r   <= status_vector[BLOCK_LOCK_BIT] | core_status[0];
            lock_rr  <= lock_r;
            hiber_r  <= status_vector[HI_BER_BIT];
            hiber_rr <= hiber_r;
        end
    end

    assign good       = lock_r & ~hiber_r;
    assign lock_fall  = lock_rr & ~lock_r;
    assign hiber_rise = hiber_r & ~hiber_rr;

    // State, shared counter and registered pulses
    always_ff @(posedge clk156) begin
        if (rst) begin
            state           <= ST_DOWN;
            ctr             <= '0;
            link_up_pulse   <= 1'b0;
            link_down_pulse <= 1'b0;
        end else begin
            state           <= state_nxt;
            ctr             <= ctr_nxt;
            link_up_pulse   <= up_pulse_nxt;
            link_down_pulse <= down_pulse_nxt;
        end
    end

    // Next-state logic; HOLD always runs its full holdoff regardless of good
    always_comb begin
        state_nxt = state;
        ctr_nxt   = ctr;
        unique case (state)
            ST_DOWN: begin
                if (good) begin
                    state_nxt = ST_QUAL;
                    ctr_nxt   = '0;
                end
            end
            ST_QUAL: begin
                if (!good) begin
                    state_nxt = ST_DOWN;
                end else if (ctr == QUAL_LAST) begin
                    state_nxt = ST_UP;
                end else begin
                    ctr_nxt = ctr + CTR_W'(1);
                end
            end
            ST_UP: begin
                if (!good) begin
                    state_nxt = ST_HOLD;
                    ctr_nxt   = '0;
                end
            end
            ST_HOLD: begin
                if (ctr == HOLD_LAST) begin
                    state_nxt = ST_DOWN;
                end else begin
                    ctr_nxt = ctr + CTR_W'(1);
                end
            end
            default: begin
                state_nxt = ST_DOWN;
                ctr_nxt   = '0;
            end
        endcase
    end

    // Transition pulses, registered one stage later with the state
    always_comb begin
        up_pulse_nxt   = (state == ST_QUAL) && good && (ctr == QUAL_LAST);
        down_pulse_nxt = (state == ST_UP) && !good;
    end

    assign link_up = (state == ST_UP);

    // Sticky flags: a new event in the clearing cycle keeps the flag set
    always_ff @(posedge clk156) begin
        if (rst) begin
            sticky_lock_lost  <= 1'b0;
            sticky_hi_ber     <= 1'b0;
            cfg_clear_status2 <= 1'b0;
        end else begin
            sticky_lock_lost  <= lock_fall  | (sticky_lock_lost & ~clear_sticky);
            sticky_hi_ber     <= hiber_rise | (sticky_hi_ber & ~clear_sticky);
            cfg_clear_status2 <= clear_sticky;
        end
    end

    sat_counter #(.W(CNT_W)) u_drop_cnt (
        .clk (clk156),
        .rst (rst),
        .inc (down_pulse_nxt),
        .clr (clear_counters),
        .q   (link_drop_cnt)
    );

    sat_counter #(.W(CNT_W)) u_hiber_cnt (
        .clk (clk156),
        .rst (rst),
        .inc (hiber_rise),
        .clr (clear_counters),
        .q   (hi_ber_cnt)
    );

endmodule

// File: tb/tb_pcs_pma_status_monitor.sv
// Self-checking bench for pcs_pma_status_monitor with short qualification
// and holdoff times. A run-length model of link qualification predicts every
// output each cycle; directed sequences pin exact cycle timing with literals,
// then a randomized phase exercises the rest.
module tb_pcs_pma_status_monitor;

    localparam int QUAL  = 16;
    localparam int HOLD  = 8;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [447:0]  status_vector = '0;
    logic [7:0]    core_status = '0;
    logic          clear_counters = 1'b0;
    logic          clear_sticky = 1'b0;
    logic          link_up, link_up_pulse, link_down_pulse;
    logic          sticky_lock_lost, sticky_hi_ber, cfg_clear_status2;
    logic [CW-1:0] link_drop_cnt, hi_ber_cnt;

    int checks = 0;
    int failures = 0;

    pcs_pma_status_monitor #(
        .QUAL_CYCLES    (QUAL),
        .HOLDOFF_CYCLES (HOLD),
        .CNT_W          (CW),
        .BLOCK_LOCK_BIT (256),
        .HI_BER_BIT     (257)
    ) dut (
        .clk156            (clk),
        .rst               (rst),
        .status_vector     (status_vector),
        .core_status       (core_status),
        .clear_counters    (clear_counters),
        .clear_sticky      (clear_sticky),
        .link_up           (link_up),
        .link_up_pulse     (link_up_pulse),
        .link_down_pulse   (link_down_pulse),
        .sticky_lock_lost  (sticky_lock_lost),
        .sticky_hi_ber     (sticky_hi_ber),
        .link_drop_cnt     (link_drop_cnt),
        .hi_ber_cnt        (hi_ber_cnt),
        .cfg_clear_status2 (cfg_clear_status2)
    );

    always #5 clk = ~clk;

    // Reference model: link comes up once QUAL+1 consecutive good cycles
    // accumulate outside UP/HOLD; a drop from UP blocks counting for HOLD cycles.
    bit m_valid = 0;
    bit m_lock_r, m_lock_rr, m_hib_r, m_hib_rr;
    bit m_up, m_up_pulse, m_down_pulse, m_st_lock, m_st_hib, m_cfg;
    int m_run, m_hold_left, m_drop, m_hib_cnt;

    always @(posedge clk) begin
        bit g, fall, rise, drop_ev;
        if (rst) begin
            m_valid = 1;
            {m_lock_r, m_lock_rr, m_hib_r, m_hib_rr} = '0;
            {m_up, m_up_pulse, m_down_pulse, m_st_lock, m_st_hib, m_cfg} = '0;
            m_run = 0; m_hold_left = 0; m_drop = 0; m_hib_cnt = 0;
        end else begin
            g = m_lock_r && !m_hib_r;
            fall = m_lock_rr && !m_lock_r;
            rise = m_hib_r && !m_hib_rr;
            drop_ev = 0;
            m_up_pulse = 0;
            m_down_pulse = 0;
            if (m_up) begin
                if (!g) begin
                    m_up = 0;
                    m_hold_left = HOLD;
                    m_down_pulse = 1;
                    drop_ev = 1;
                end
            end else if (m_hold_left > 0) begin
                m_hold_left--;
                m_run = 0;
            end else begin
                m_run = g ? m_run + 1 : 0;
                if (m_run == QUAL + 1) begin
                    m_up = 1;
                    m_up_pulse = 1;
                    m_run = 0;
                end
            end
            m_st_lock = fall || (m_st_lock && !clear_sticky);
            m_st_hib  = rise || (m_st_hib && !clear_sticky);
            if (clear_counters) m_drop = 0;
            else if (drop_ev && m_drop < CMAX) m_drop++;
            if (clear_counters) m_hib_cnt = 0;
            else if (rise && m_hib_cnt < CMAX) m_hib_cnt++;
            m_cfg = clear_sticky;
            m_lock_rr = m_lock_r;
            m_lock_r  = status_vector[256] | core_status[0];
            m_hib_rr  = m_hib_r;
            m_hib_r   = status_vector[257];
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        logic [13:0] got, exp;
        if (m_valid) begin
            got = {link_up, link_up_pulse, link_down_pulse, sticky_lock_lost,
                   sticky_hi_ber, cfg_clear_status2, link_drop_cnt, hi_ber_cnt};
            exp = {m_up, m_up_pulse, m_down_pulse, m_st_lock, m_st_hib, m_cfg,
                   CW'(m_drop), CW'(m_hib_cnt)};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("[TB] FAIL model_compare t=%0t got=%b expected=%b", $time, got, exp);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s t=%0t got=%0h expected=%0h", name, $time, got, exp);
        end
    endtask

    // Drive one cycle of inputs (block lock from a random source, noise elsewhere)
    // and advance to the next falling edge.
    task automatic applyStimulus(input logic lock, input logic hiber, input logic cc,
                                 input logic cs, input logic r);
        logic [447:0] sv;
        int src;
        for (int w = 0; w < 14; w++) sv[w*32 +: 32] = $urandom;
        src = $urandom_range(0, 2);
        sv[256] = lock && (src != 1);
        sv[257] = hiber;
        status_vector  = sv;
        core_status    = {7'($urandom), lock && (src != 0)};
        clear_counters = cc;
        clear_sticky   = cs;
        rst            = r;
        @(negedge clk);
    endtask

    task automatic step(input logic lock, input logic hiber);
        applyStimulus(lock, hiber, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic waitLinkUp();
        for (int n = 0; n < 64 && !link_up; n++) step(1'b1, 1'b0);
        checkOutput("wait_link_up", link_up, 1);
    endtask

    initial begin
        bit lk, hb;
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 1);
        step(0, 0);
        checkOutput("reset_outputs",
                    {link_up, link_up_pulse, link_down_pulse, sticky_lock_lost,
                     sticky_hi_ber, cfg_clear_status2, link_drop_cnt, hi_ber_cnt}, 0);

        // Good from input cycle 0: link_up and its pulse appear at cycle 18
        for (int i = 1; i <= 19; i++) begin
            step(1, 0);
            if (i == 17) checkOutput("qual_cycle17_down", link_up, 0);
            if (i == 18) checkOutput("qual_cycle18_up", {link_up, link_up_pulse}, 2'b11);
            if (i == 19) checkOutput("qual_pulse_single", link_up_pulse, 0);
        end

        // hi_ber blip in UP, good returns at once; holdoff then re-qualify
        step(1, 1);
        checkOutput("hiber_c1_still_up", {link_up, link_down_pulse}, 2'b10);
        for (int i = 2; i <= 27; i++) begin
            step(1, 0);
            if (i == 2) begin
                checkOutput("hiber_c2_down_pulse", {link_up, link_down_pulse}, 2'b01);
                checkOutput("hiber_c2_drop_cnt", link_drop_cnt, 1);
                checkOutput("hiber_c2_hiber_cnt", hi_ber_cnt, 1);
                checkOutput("hiber_c2_sticky", sticky_hi_ber, 1);
            end
            if (i == 26) checkOutport_dummy();
            if (i == 27) checkOutput("requal_c27_up", link_up, 1);
        end

        // Lock lost in QUAL never brings the link up and never counts a drop
        for (int i = 0; i < 12; i++) step(0, 0);
        applyStimulus(0, 0, 1, 1, 0);
        step(0, 0);
        checkOutput("cleared_sticky_lock", sticky_lock_lost, 0);
        checkOutput("cleared_drop_cnt", link_drop_cnt, 0);
        for (int i = 1; i <= 22; i++) begin
            step(i <= 10, 0);
            if (i == 20) begin
                checkOutput("qual_abort_link", link_up, 0);
                checkOutput("qual_abort_sticky", sticky_lock_lost, 1);
                checkOutput("qual_abort_drop_cnt", link_drop_cnt, 0);
            end
        end

        // clear_sticky coinciding with a lock falling edge: the set wins
        waitLinkUp();
        applyStimulus(1, 0, 0, 1, 0);
        step(1, 0);
        checkOutput("sticky_pre_clear", sticky_lock_lost, 0);
        step(0, 0);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("sticky_set_wins", {sticky_lock_lost, cfg_clear_status2}, 2'b11);
        step(0, 0);
        checkOutput("cfg_pulse_one_cycle", {sticky_lock_lost, cfg_clear_status2}, 2'b10);

        // 20 more drops saturate the drop counter
        for (int d = 0; d < 20; d++) begin
            waitLinkUp();
            step(0, 0);
            step(0, 0);
        end
        checkOutput("drop_cnt_saturated", link_drop_cnt, CMAX);

        // clear_counters in the increment cycle: result 0, event lost
        waitLinkUp();
        step(0, 0);
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("clear_beats_inc", link_drop_cnt, 0);
        step(0, 0);
        checkOutput("clear_beats_inc_hold", link_drop_cnt, 0);

        // Reset from UP: everything back to zero with no down pulse
        waitLinkUp();
        applyStimulus(1, 0, 0, 0, 1);
        checkOutput("rst_in_up",
                    {link_up, link_up_pulse, link_down_pulse, sticky_lock_lost,
                     sticky_hi_ber, cfg_clear_status2, link_drop_cnt, hi_ber_cnt}, 0);

        // Randomized phase: slowly changing lock/hi_ber with random clears
        lk = 1; hb = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 39) == 0) lk = !lk;
            if ($urandom_range(0, 59) == 0) hb = !hb;
            applyStimulus(lk, hb, $urandom_range(0, 49) == 0,
                          $urandom_range(0, 29) == 0, $urandom_range(0, 499) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Cycle 26 after the hi_ber blip is the last holdoff/qualification cycle
    task automatic checkOutport_dummy();
        checkOutput("requal_c26_down", link_up, 0);
    endtask

endmodule
